div_unit: RTL

//   Iterative radix-2 integer divider executing RV32M DIV/DIVU/REM/REMU ops issued by the decode-stage divsel code.

---
 rtl/div_unit_pkg.sv | 29 ++
 rtl/div_unit_if.sv | 26 ++
 rtl/div_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared divider definitions: divsel encodings, FSM state type and the
// conditional two's-complement helper used for |x| and sign fix-up.
package riscv_pkg;

    // divsel encodings issued by decode; any other code is ignored by the divider
    localparam logic [2:0] DIV_DIV  = 3'b001;
    localparam logic [2:0] DIV_DIVU = 3'b010;
    localparam logic [2:0] DIV_REM  = 3'b011;
    localparam logic [2:0] DIV_REMU = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    // Helper width; callers zero-extend into it and truncate the result, so it
    // serves any XLEN up to 64 (negation wraps correctly in the low bits).
    localparam int unsigned NEG_W = 64;

    // Two's-complement negate (~x+1, wrapping) when en is set, pass-through otherwise.
    function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] x, input logic en);
        logic [NEG_W-1:0] one;
        one = {{(NEG_W-1){1'b0}}, 1'b1};
        return en ? (~x + one) : x;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Issue/result bundle between the EX stage (master) and the divider (slave).
interface div_unit_if
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      divsel;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            flush;
    logic            ready;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, divsel, rs1_val, rs2_val, flush,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, divsel, rs1_val, rs2_val, flush,
        output ready, busy, done, result
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in the
// accept cycle. done and result are flops; ready/busy decode the state register.
module div_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic        clk,
    input logic        rst_n,
    div_unit_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       state_q;
    logic [2:0]       op_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvs_q;
    logic             sign_quo_q;
    logic             sign_rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic [XLEN-1:0]  result_q;

    logic             op_valid;
    logic             is_signed_in;
    logic             is_rem_in;
    logic             rs1_neg;
    logic             rs2_neg;
    logic [XLEN-1:0]  abs1;
    logic [XLEN-1:0]  abs2;
    logic             div_zero;
    logic             ovf;
    logic             special;
    logic [XLEN-1:0]  special_res;

    logic             op_rem;
    logic [XLEN:0]    rem_sh;
    logic [XLEN-1:0]  rem_nx;
    logic [XLEN-1:0]  quo_nx;
    logic [XLEN-1:0]  q_fin;
    logic [XLEN-1:0]  r_fin;
    logic [XLEN-1:0]  fix_res;

    // Decode the incoming request and resolve the single-cycle special cases.
    always_comb begin
        op_valid     = 1'b0;
        is_signed_in = 1'b0;
        is_rem_in    = 1'b0;
        case (bus.divsel)
            DIV_DIV:  begin op_valid = 1'b1; is_signed_in = 1'b1; end
            DIV_DIVU: begin op_valid = 1'b1; end
            DIV_REM:  begin op_valid = 1'b1; is_signed_in = 1'b1; is_rem_in = 1'b1; end
            DIV_REMU: begin op_valid = 1'b1; is_rem_in = 1'b1; end
            default:  ;
        endcase
        rs1_neg  = is_signed_in & bus.rs1_val[XLEN-1];
        rs2_neg  = is_signed_in & bus.rs2_val[XLEN-1];
        abs1     = XLEN'(cond_neg(NEG_W'(bus.rs1_val), rs1_neg));
        abs2     = XLEN'(cond_neg(NEG_W'(bus.rs2_val), rs2_neg));
        div_zero = (bus.rs2_val == '0);
        ovf      = is_signed_in && (bus.rs1_val == MIN_NEG) && (bus.rs2_val == '1);
        special  = div_zero | ovf;
        // Zero divisor: q = -1, r = dividend. Overflow: q = dividend, r = 0.
        if (div_zero) begin
            special_res = is_rem_in ? bus.rs1_val : '1;
        end else if (is_rem_in) begin
            special_res = '0;
        end else begin
            special_res = bus.rs1_val;
        end
    end

    // One restoring step on {rem,quo} plus the sign fix-up applied in FIX.
    always_comb begin
        op_rem = (op_q == DIV_REM) || (op_q == DIV_REMU);
        rem_sh = {rem_q, quo_q[XLEN-1]};
        if (rem_sh >= {1'b0, dvs_q}) begin
            // Difference is below the divisor, so it always fits in XLEN bits.
            rem_nx = rem_sh[XLEN-1:0] - dvs_q;
            quo_nx = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[XLEN-1:0];
            quo_nx = {quo_q[XLEN-2:0], 1'b0};
        end
        // Sign flags are only ever set for signed ops.
        q_fin   = XLEN'(cond_neg(NEG_W'(quo_q), sign_quo_q));
        r_fin   = XLEN'(cond_neg(NEG_W'(rem_q), sign_rem_q));
        fix_res = op_rem ? r_fin : q_fin;
    end

    // Control FSM with registered done/result; flush overrides everything but reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && op_valid) begin
                        op_q       <= bus.divsel;
                        quo_q      <= abs1;
                        rem_q      <= '0;
                        dvs_q      <= abs2;
                        sign_quo_q <= rs1_neg ^ rs2_neg;
                        sign_rem_q <= rs1_neg;
                        cnt_q      <= CNT_W'(XLEN);
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fix_res;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = (state_q == IDLE);
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
